// File: rtl/polygon_loader.sv
// Double-buffered vertex loader: assembles a polygon in a shadow bank and swaps it into the active bank on new_frame_in.
// Optional POLYGON_LOADER_BBOX_EN adds a bounding box that is tracked per polygon and swapped together with the banks.
module polygon_loader #(
    parameter int unsigned MAX_NUM_VERTICES = 8,
    parameter int unsigned COORD_WIDTH      = 32,
    localparam int unsigned CNT_W           = $clog2(MAX_NUM_VERTICES + 1)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          vertex_valid_in,
    output logic                          vertex_ready_out,
    input  logic signed [COORD_WIDTH-1:0] vertex_x_in,
    input  logic signed [COORD_WIDTH-1:0] vertex_y_in,
    input  logic                          vertex_last_in,
    input  logic                          new_frame_in,
    output logic signed [COORD_WIDTH-1:0] poly_xs_out [MAX_NUM_VERTICES],
    output logic signed [COORD_WIDTH-1:0] poly_ys_out [MAX_NUM_VERTICES],
    output logic        [CNT_W-1:0]       num_points_out,
    output logic                          pending_out,
    output logic                          overflow_out,
    output logic                          degenerate_out
`ifdef POLYGON_LOADER_BBOX_EN
    ,
    output logic signed [COORD_WIDTH-1:0] bbox_xmin_out,
    output logic signed [COORD_WIDTH-1:0] bbox_xmax_out,
    output logic signed [COORD_WIDTH-1:0] bbox_ymin_out,
    output logic signed [COORD_WIDTH-1:0] bbox_ymax_out
`endif
);

    localparam int unsigned    IDX_W   = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NUM_VERTICES);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(3);

    typedef enum logic {
        ACCEPT  = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]              wr_idx;
    logic [CNT_W-1:0]              shadow_count;
    logic signed [COORD_WIDTH-1:0] shadow_xs [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] shadow_ys [MAX_NUM_VERTICES];
    logic                          overflow_seen;

    logic             handshake;
    logic             store;
    logic             closing;
    logic             swap;
    logic             full;
    logic             keep;
    logic [CNT_W-1:0] close_count;

    assign full        = (wr_idx == MAX_CNT);
    assign close_count = full ? MAX_CNT : wr_idx + CNT_W'(1);
    assign keep        = (close_count >= MIN_CNT);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        vertex_ready_out = (state == ACCEPT);
        pending_out      = (state == PENDING);
        handshake        = vertex_valid_in && (state == ACCEPT);
        store            = handshake && !full;
        closing          = handshake && vertex_last_in;
        swap             = (state == PENDING) && new_frame_in;
        case (state)
            ACCEPT:  if (closing && keep) state_next = PENDING;
            PENDING: if (new_frame_in) state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_idx         <= '0;
            shadow_count   <= '0;
            overflow_seen  <= 1'b0;
            overflow_out   <= 1'b0;
            degenerate_out <= 1'b0;
            num_points_out <= '0;
            for (int unsigned i = 0; i < MAX_NUM_VERTICES; i++) begin
                shadow_xs[i]   <= '0;
                shadow_ys[i]   <= '0;
                poly_xs_out[i] <= '0;
                poly_ys_out[i] <= '0;
            end
        end else begin
            overflow_out   <= 1'b0;
            degenerate_out <= 1'b0;

            if (store) begin
                shadow_xs[wr_idx[IDX_W-1:0]] <= vertex_x_in;
                shadow_ys[wr_idx[IDX_W-1:0]] <= vertex_y_in;
                wr_idx                       <= wr_idx + CNT_W'(1);
            end

            if (handshake && full && !overflow_seen) begin
                overflow_out  <= 1'b1;
                overflow_seen <= 1'b1;
            end

            // Closing after the overflow update: a dropped last beat still pulses, then re-arms for the next polygon.
            if (closing) begin
                overflow_seen <= 1'b0;
                if (keep) begin
                    shadow_count <= close_count;
                end else begin
                    degenerate_out <= 1'b1;
                    wr_idx         <= '0;
                end
            end

            if (swap) begin
                for (int unsigned i = 0; i < MAX_NUM_VERTICES; i++) begin
                    poly_xs_out[i] <= shadow_xs[i];
                    poly_ys_out[i] <= shadow_ys[i];
                end
                num_points_out <= shadow_count;
                wr_idx         <= '0;
            end
        end
    end

`ifdef POLYGON_LOADER_BBOX_EN
    logic signed [COORD_WIDTH-1:0] shadow_xmin;
    logic signed [COORD_WIDTH-1:0] shadow_xmax;
    logic signed [COORD_WIDTH-1:0] shadow_ymin;
    logic signed [COORD_WIDTH-1:0] shadow_ymax;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shadow_xmin   <= '0;
            shadow_xmax   <= '0;
            shadow_ymin   <= '0;
            shadow_ymax   <= '0;
            bbox_xmin_out <= '0;
            bbox_xmax_out <= '0;
            bbox_ymin_out <= '0;
            bbox_ymax_out <= '0;
        end else begin
            if (store) begin
                if (wr_idx == '0) begin
                    shadow_xmin <= vertex_x_in;
                    shadow_xmax <= vertex_x_in;
                    shadow_ymin <= vertex_y_in;
                    shadow_ymax <= vertex_y_in;
                end else begin
                    if (vertex_x_in < shadow_xmin) shadow_xmin <= vertex_x_in;
                    if (vertex_x_in > shadow_xmax) shadow_xmax <= vertex_x_in;
                    if (vertex_y_in < shadow_ymin) shadow_ymin <= vertex_y_in;
                    if (vertex_y_in > shadow_ymax) shadow_ymax <= vertex_y_in;
                end
            end
            if (swap) begin
                bbox_xmin_out <= shadow_xmin;
                bbox_xmax_out <= shadow_xmax;
                bbox_ymin_out <= shadow_ymin;
                bbox_ymax_out <= shadow_ymax;
            end
        end
    end
`endif

endmodule

// File: tb/tb_polygon_loader.sv
// Directed bench for polygon_loader: a cycle table for handshake/flag/count behaviour plus reset sequences.
module tb_polygon_loader;

    localparam int NV = 8;
    localparam int CW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid = 1'b0;
    logic                 ready;
    logic signed [CW-1:0] vx = '0;
    logic signed [CW-1:0] vy = '0;
    logic                 last = 1'b0;
    logic                 new_frame = 1'b0;
    logic signed [CW-1:0] xs [NV];
    logic signed [CW-1:0] ys [NV];
    logic [3:0]           num_points;
    logic                 pending;
    logic                 overflow;
    logic                 degenerate;
`ifdef POLYGON_LOADER_BBOX_EN
    logic signed [CW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
`endif

    polygon_loader #(.MAX_NUM_VERTICES(NV), .COORD_WIDTH(CW)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .vertex_valid_in (valid),
        .vertex_ready_out(ready),
        .vertex_x_in     (vx),
        .vertex_y_in     (vy),
        .vertex_last_in  (last),
        .new_frame_in    (new_frame),
        .poly_xs_out     (xs),
        .poly_ys_out     (ys),
        .num_points_out  (num_points),
        .pending_out     (pending),
        .overflow_out    (overflow),
        .degenerate_out  (degenerate)
`ifdef POLYGON_LOADER_BBOX_EN
        ,
        .bbox_xmin_out   (bb_xmin),
        .bbox_xmax_out   (bb_xmax),
        .bbox_ymin_out   (bb_ymin),
        .bbox_ymax_out   (bb_ymax)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        int   x;
        int   y;
        logic lst;
        logic nf;
        logic rdy;
        logic pend;
        logic ovf;
        logic deg;
        int   num;
        int   bank;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Expected active banks: 0 reset, 1 pentagon, 2 triangle T, 3 overflow, 4 triangle U, 5 triangle V, 6 square
    int exp_xs [7][NV];
    int exp_ys [7][NV];
    int exp_n  [7];
    int exp_bb [7][4];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bank(input int b, input string tag);
        for (int i = 0; i < NV; i++) begin
            if (b == 0 || i < exp_n[b]) begin
                check($sformatf("%s xs[%0d]", tag, i), xs[i], exp_xs[b][i]);
                check($sformatf("%s ys[%0d]", tag, i), ys[i], exp_ys[b][i]);
            end
        end
`ifdef POLYGON_LOADER_BBOX_EN
        check({tag, " bbox_xmin"}, bb_xmin, exp_bb[b][0]);
        check({tag, " bbox_xmax"}, bb_xmax, exp_bb[b][1]);
        check({tag, " bbox_ymin"}, bb_ymin, exp_bb[b][2]);
        check({tag, " bbox_ymax"}, bb_ymax, exp_bb[b][3]);
`endif
    endtask

    task automatic check_flags(input string tag, input logic rdy, input logic pend,
                               input logic ovf, input logic deg, input int num);
        check({tag, " ready"}, ready, rdy);
        check({tag, " pending"}, pending, pend);
        check({tag, " overflow"}, overflow, ovf);
        check({tag, " degenerate"}, degenerate, deg);
        check({tag, " num_points"}, num_points, num);
    endtask

    task automatic add(input logic v, input int x, input int y, input logic lst, input logic nf,
                       input logic rdy, input logic pend, input logic ovf, input logic deg,
                       input int num, input int bank);
        vec_t r;
        r.v = v; r.x = x; r.y = y; r.lst = lst; r.nf = nf;
        r.rdy = rdy; r.pend = pend; r.ovf = ovf; r.deg = deg; r.num = num; r.bank = bank;
        vecs.push_back(r);
    endtask

    task automatic step(input logic v, input int x, input int y, input logic lst, input logic nf);
        @(negedge clk);
        valid = v; vx = x; vy = y; last = lst; new_frame = nf;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        valid = 1'b0; last = 1'b0; new_frame = 1'b0;
        rst_n = 1'b0;
        #1;
        check_flags(tag, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_bank(0, tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_bank(input int b, input int n, input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input int x3, input int y3, input int x4, input int y4);
        int tx [5];
        int ty [5];
        tx = '{x0, x1, x2, x3, x4};
        ty = '{y0, y1, y2, y3, y4};
        exp_n[b] = n;
        for (int i = 0; i < n; i++) begin
            exp_xs[b][i] = tx[i];
            exp_ys[b][i] = ty[i];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 7; b++) begin
            exp_n[b] = 0;
            for (int i = 0; i < NV; i++) begin
                exp_xs[b][i] = 0;
                exp_ys[b][i] = 0;
            end
            for (int k = 0; k < 4; k++) exp_bb[b][k] = 0;
        end
        set_bank(1, 5, 700, 250, 700, 150, 800, 50, 900, 150, 900, 250);
        exp_bb[1] = '{700, 900, 50, 250};
        set_bank(2, 3, -10, -20, 30, -40, 50, 60, 0, 0, 0, 0);
        exp_bb[2] = '{-10, 50, -40, 60};
        exp_n[3] = 8;
        for (int i = 0; i < 8; i++) begin
            exp_xs[3][i] = (i + 1) * 10;
            exp_ys[3][i] = -3 * (i + 1);
        end
        exp_bb[3] = '{10, 80, -24, -3};
        set_bank(4, 3, 11, 12, 13, 14, 15, 16, 0, 0, 0, 0);
        exp_bb[4] = '{11, 15, 12, 16};
        set_bank(5, 3, 77, 88, 78, 89, 79, 90, 0, 0, 0, 0);
        exp_bb[5] = '{77, 79, 88, 90};
        set_bank(6, 4, 100, 100, 100, 200, 200, 200, 200, 100, 0, 0);
        exp_bb[6] = '{100, 200, 100, 200};

        // Pentagon, then swap
        add(1, 700, 250, 0, 0, 1, 0, 0, 0, 0, -1);
        add(1, 700, 150, 0, 0, 1, 0, 0, 0, 0, -1);
        add(1, 800,  50, 0, 0, 1, 0, 0, 0, 0, -1);
        add(1, 900, 150, 0, 0, 1, 0, 0, 0, 0, -1);
        add(1, 900, 250, 1, 0, 0, 1, 0, 0, 0,  0);
        add(0,   0,   0, 0, 0, 0, 1, 0, 0, 0, -1);
        add(0,   0,   0, 0, 1, 1, 0, 0, 0, 5,  1);
        // Last beat coincident with new_frame: no swap until the next pulse
        add(1, -10, -20, 0, 0, 1, 0, 0, 0, 5, -1);
        add(1,  30, -40, 0, 0, 1, 0, 0, 0, 5, -1);
        add(1,  50,  60, 1, 1, 0, 1, 0, 0, 5,  1);
        add(0,   0,   0, 0, 0, 0, 1, 0, 0, 5,  1);
        add(0,   0,   0, 0, 1, 1, 0, 0, 0, 3,  2);
        add(0,   0,   0, 0, 1, 1, 0, 0, 0, 3,  2);
        // Ten beats into eight slots, new_frame mid-load ignored
        for (int i = 1; i <= 10; i++) begin
            if (i < 10) add(1, i * 10, -3 * i, 0, (i == 2), 1, 0, (i == 9), 0, 3, -1);
            else        add(1, i * 10, -3 * i, 1, 0,        0, 1, 0,        0, 3,  2);
        end
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 8, 3);
        // Degenerate polygons and last without valid
        add(1, 7,  8, 0, 0, 1, 0, 0, 0, 8, -1);
        add(1, 9, 10, 1, 0, 1, 0, 0, 1, 8, -1);
        add(0, 0,  0, 0, 1, 1, 0, 0, 0, 8,  3);
        add(1, 1,  1, 1, 0, 1, 0, 0, 1, 8, -1);
        add(0, 0,  0, 1, 0, 1, 0, 0, 0, 8,  3);
        // Valid held through PENDING becomes vertex 0 after the swap
        add(1, 11, 12, 0, 0, 1, 0, 0, 0, 8, -1);
        add(1, 13, 14, 0, 0, 1, 0, 0, 0, 8, -1);
        add(1, 15, 16, 1, 0, 0, 1, 0, 0, 8, -1);
        add(1, 77, 88, 0, 0, 0, 1, 0, 0, 8,  3);
        add(1, 77, 88, 0, 0, 0, 1, 0, 0, 8, -1);
        add(1, 77, 88, 0, 1, 1, 0, 0, 0, 3,  4);
        add(1, 77, 88, 0, 0, 1, 0, 0, 0, 3, -1);
        add(1, 78, 89, 0, 0, 1, 0, 0, 0, 3, -1);
        add(1, 79, 90, 1, 0, 0, 1, 0, 0, 3, -1);
        add(0,  0,  0, 0, 1, 1, 0, 0, 0, 3,  5);

        // Reset state
        #12;
        check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_bank(0, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[r]) begin
            step(vecs[r].v, vecs[r].x, vecs[r].y, vecs[r].lst, vecs[r].nf);
            check_flags($sformatf("row%0d", r), vecs[r].rdy, vecs[r].pend, vecs[r].ovf, vecs[r].deg, vecs[r].num);
            if (vecs[r].bank >= 0) check_bank(vecs[r].bank, $sformatf("row%0d", r));
        end

        // Reset mid-load, then a fresh square
        step(1, 5, 5, 0, 0);
        step(1, 6, 6, 0, 0);
        step(1, 7, 7, 0, 0);
        pulse_reset("rst_midload");
        step(1, 100, 100, 0, 0);
        step(1, 100, 200, 0, 0);
        step(1, 200, 200, 0, 0);
        step(1, 200, 100, 1, 0);
        check_flags("square_loaded", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(0, 0, 0, 0, 1);
        check_flags("square_swap", 1'b1, 1'b0, 1'b0, 1'b0, 4);
        check_bank(6, "square_swap");

        // Reset in PENDING discards the shadow polygon
        step(1, 1, 2, 0, 0);
        step(1, 3, 4, 0, 0);
        step(1, 5, 6, 1, 0);
        check_flags("pend_loaded", 1'b0, 1'b1, 1'b0, 1'b0, 4);
        pulse_reset("rst_pending");
        step(0, 0, 0, 0, 1);
        check_flags("after_rst_frame", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_bank(0, "after_rst_frame");

        step(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/polygon_loader.md
# polygon_loader

Double-buffered vertex loader that sits directly upstream of `in_polygon`. It accepts a polygon as a stream of signed vertices over a valid/ready handshake and assembles it in a shadow bank. At the next frame boundary it swaps the shadow bank atomically into the active arrays that drive `in_polygon`'s `poly_xs_in`, `poly_ys_in` and `num_points_in`. The pixel test therefore never sees a half-written polygon mid-frame.

## Interface
- `MAX_NUM_VERTICES`, 8, capacity of both banks.
- `COORD_WIDTH`, 32, signed coordinate width.
- `clk_in` input 1: system clock, all state on rising edge.
- `rst_in` input 1: reset, asynchronous, active-low.
- `vertex_valid_in` input 1: a vertex beat is offered.
- `vertex_ready_out` output 1: loader accepts the beat this cycle.
- `vertex_x_in` input `COORD_WIDTH` signed: vertex x.
- `vertex_y_in` input `COORD_WIDTH` signed: vertex y.
- `vertex_last_in` input 1: this beat closes the polygon.
- `new_frame_in` input 1: single-cycle frame-boundary pulse (vsync).
- `poly_xs_out[MAX_NUM_VERTICES]` output `COORD_WIDTH` signed: active x bank.
- `poly_ys_out[MAX_NUM_VERTICES]` output `COORD_WIDTH` signed: active y bank.
- `num_points_out` output `$clog2(MAX_NUM_VERTICES+1)`: active vertex count.
- `pending_out` output 1: a completed polygon is waiting for a swap.
- `overflow_out` output 1: one-cycle pulse when excess vertices are dropped.
- `degenerate_out` output 1: one-cycle pulse when a polygon with fewer than 3 vertices is discarded.

## Operation
- Two-state FSM: ACCEPT and PENDING.
- **ACCEPT**
  - `vertex_ready_out`=1.
  - On each handshake (valid && ready), write x/y to shadow[`wr_idx`] and increment `wr_idx`.
  - When `wr_idx` = `MAX_NUM_VERTICES`, further beats are still accepted but not stored, and `overflow_out` pulses once per polygon.
  - On a handshake with `vertex_last_in`, the stored count is `min(wr_idx+1, MAX)`.
    - Count ≥ 3: latch the count into `shadow_count` and go to PENDING.
    - Count < 3: pulse `degenerate_out`, clear `wr_idx`, stay in ACCEPT.
- **PENDING**
  - `vertex_ready_out`=0 and `pending_out`=1.
  - On `new_frame_in`, copy the whole shadow bank and count into the active outputs, clear `wr_idx`, and go to ACCEPT.
- `new_frame_in` in ACCEPT has no effect. A partially loaded polygon keeps loading and the active bank is unchanged.
- Active slots at index ≥ `num_points_out` hold stale data. The downstream block indexes only below `num_points_out`.
- `vertex_last_in` without `vertex_valid_in` is ignored.

## Timing
- `vertex_ready_out` and `pending_out` are decoded from registered state only, with no combinational path from inputs.
- Last beat accepted at edge N: PENDING at N, `pending_out`=1 in cycle N+1.
- If `new_frame_in` is high in the same cycle as the last beat, the swap does not happen. The polygon waits for the next `new_frame_in`.
- `new_frame_in` sampled in PENDING at edge M: the active bank, `num_points_out` and `vertex_ready_out`=1 all update at M together.
- Throughput is one vertex per cycle in ACCEPT.
- `overflow_out` and `degenerate_out` are registered pulses asserted the cycle after the offending beat.
- Reset values:
  - State ACCEPT, `wr_idx`=0, `vertex_ready_out`=1, `pending_out`=0.
  - Both flags 0, all active and shadow coordinates 0, `num_points_out`=0.
- Reset asserted mid-load or in PENDING discards the shadow contents.

## Configuration
- `POLYGON_LOADER_BBOX_EN` defined:
  - Adds outputs `bbox_xmin_out`, `bbox_xmax_out`, `bbox_ymin_out`, `bbox_ymax_out` (`COORD_WIDTH` signed).
  - The shadow bbox is updated on each stored vertex using signed compares and is seeded by the first vertex.
  - It swaps into the active bbox together with the banks; reset value is 0.
  - Downstream uses it for early rejection of pixels outside the box.
- Undefined: the ports and logic are absent, and the rest of the behaviour is identical.

## Test plan
- Pentagon (700,250),(700,150),(800,50),(900,150),(900,250) with last on beat 5, then `new_frame_in` -> `num_points_out`=5, banks match, `pending_out` 1→0. With BBOX_EN: bbox = 700/900/50/250.
- Last beat coincident with `new_frame_in` -> no swap and `pending_out`=1. The next `new_frame_in` swaps and the prior active polygon is held until then.
- 10 beats with `MAX_NUM_VERTICES`=8 -> `overflow_out` pulses once, `num_points_out`=8, beats 9–10 not stored, ready stays 1 until last.
- 2-beat polygon -> `degenerate_out` pulses, no PENDING, the active bank is unchanged after `new_frame_in`.
- Valid held high while in PENDING -> ready=0 and no writes. After the swap the held beat is accepted as vertex 0 of the next polygon.
- Reset pulsed after 3 beats -> all outputs at reset values. A fresh 4-vertex square (100,100),(100,200),(200,200),(200,100) then loads and swaps with `num_points_out`=4.
